// File: rtl/div_unit.sv
`timescale 1ns/1ps
// div_unit: iterative radix-2 restoring divider for the EX stage.
// Produces one quotient bit per clock; one operation in flight at a time.
// Result is {remainder, quotient}, valid while ready_o is high.
//
// Ports:
//   clk              core clock, rising edge
//   rst              synchronous active-high reset
//   div_start        divide request, held until ready_o is seen
//   div_signed       1 = signed (DIV), 0 = unsigned (DIVU)
//   dividend         operand A
//   divisor          operand B
//   annul            flush: abandons the current operation
//   result_o         {remainder, quotient}
//   ready_o          result valid this cycle
//   stallreq_for_ex  stall request toward the pipeline controller
//
// Build option: define DIV_EARLY_OUT_EN to finish in two cycles when |A| < |B|.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_for_ex
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   rem_q, rem_n;
  logic [WIDTH-1:0]   quo_q, quo_n;
  logic [WIDTH-1:0]   dsr_q, dsr_n;
  logic               neg_quo_q, neg_quo_n;
  logic               neg_rem_q, neg_rem_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [2*WIDTH-1:0] res_n;
  logic               rdy_n;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               borrow;
  logic [WIDTH-1:0]   step_rem, step_quo;

  // Combinational stall: held from the first request cycle until ready rises.
  assign stallreq_for_ex = div_start & ~ready_o & ~annul;

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    abs_a    = (div_signed && dividend[WIDTH-1]) ? (-dividend) : dividend;
    abs_b    = (div_signed && divisor[WIDTH-1])  ? (-divisor)  : divisor;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, dsr_q};
    borrow   = trial[WIDTH+1];
    step_rem = borrow ? WIDTH'(shifted) : WIDTH'(trial);
    step_quo = {quo_q[WIDTH-2:0], ~borrow};
  end

  // Next-state and datapath update.
  always_comb begin
    state_n   = state;
    rem_n     = rem_q;
    quo_n     = quo_q;
    dsr_n     = dsr_q;
    neg_quo_n = neg_quo_q;
    neg_rem_n = neg_rem_q;
    cnt_n     = cnt_q;
    res_n     = result_o;

    unique case (state)
      IDLE: begin
        if (div_start && !annul) begin
          if (divisor == '0) begin
            state_n = DIVZERO;
            rem_n   = '0;
          end
`ifdef DIV_EARLY_OUT_EN
          // Short path shared with divide-by-zero: quotient 0, remainder = A.
          else if (abs_a < abs_b) begin
            state_n = DIVZERO;
            rem_n   = dividend;
          end
`endif
          else begin
            state_n   = BUSY;
            rem_n     = '0;
            quo_n     = abs_a;
            dsr_n     = abs_b;
            neg_quo_n = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_n = div_signed & dividend[WIDTH-1];
            cnt_n     = '0;
          end
        end
      end

      DIVZERO: begin
        res_n   = {rem_q, {WIDTH{1'b0}}};
        state_n = DONE;
      end

      BUSY: begin
        if (annul) begin
          state_n = IDLE;
        end else begin
          rem_n = step_rem;
          quo_n = step_quo;
          cnt_n = CW'(cnt_q + 1'b1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_n = DONE;
            res_n   = {(neg_rem_q ? (-step_rem) : step_rem),
                       (neg_quo_q ? (-step_quo) : step_quo)};
          end
        end
      end

      DONE: begin
        if (!div_start || annul) begin
          state_n = IDLE;
          res_n   = '0;
        end
      end

      default: state_n = IDLE;
    endcase

    rdy_n = (state_n == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      state     <= state_n;
      rem_q     <= rem_n;
      quo_q     <= quo_n;
      dsr_q     <= dsr_n;
      neg_quo_q <= neg_quo_n;
      neg_rem_q <= neg_rem_n;
      cnt_q     <= cnt_n;
      result_o  <= res_n;
      ready_o   <= rdy_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
// tb_div_unit: directed bench for div_unit (WIDTH = 32).
// Cycle 0 is the cycle in which the request is first presented in IDLE.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_for_ex;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .div_start       (div_start),
    .div_signed      (div_signed),
    .dividend        (dividend),
    .divisor         (divisor),
    .annul           (annul),
    .result_o        (result_o),
    .ready_o         (ready_o),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide, measure latency, check result, hold in DONE, then release.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int lat, input logic [63:0] exp);
    int cyc;
    bit stall_ok;
    @(negedge clk);
    dividend = a; divisor = b; div_signed = s; div_start = 1'b1; annul = 1'b0;
    #1;
    cyc = 0;
    stall_ok = 1'b1;
    while (!ready_o && cyc < 100) begin
      if (stallreq_for_ex !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_stall_before_ready"}, 64'(stall_ok), 64'd1);
    check({tag, "_stall_at_ready"}, 64'(stallreq_for_ex), 64'd0);
    // Inputs change while DONE is held; result must not move.
    dividend = 32'hDEADBEEF; divisor = 32'h0;
    @(negedge clk);
    check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_result"}, result_o, exp);
    div_start = 1'b0;
    @(negedge clk);
    check({tag, "_release_ready"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    int early_lat;
    bit saw_ready;

    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; annul = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_for_ex), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 33, {32'h00000002, 32'h0000000E});
    run_op("sdiv_m7_2", 32'hFFFFFFF9, 32'h00000002, 1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("sdiv_7_m2", 32'h00000007, 32'hFFFFFFFE, 1'b1, 33, {32'h00000001, 32'hFFFFFFFD});
    run_op("sdiv_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, {32'h00000000, 32'h80000000});
    run_op("udiv_big", 32'hFFFFFFFF, 32'h00000003, 1'b0, 33, {32'h00000000, 32'h55555555});
    run_op("udiv_max_u", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, {32'h00000001, 32'h00000001});
    run_op("divzero_u", 32'h12345678, 32'h0, 1'b0, 2, 64'h0);
    run_op("divzero_s", 32'hFFFFFFFB, 32'h0, 1'b1, 2, 64'h0);

`ifdef DIV_EARLY_OUT_EN
    early_lat = 2;
`else
    early_lat = 33;
`endif
    run_op("udiv_5_9", 32'd5, 32'd9, 1'b0, early_lat, {32'h00000005, 32'h00000000});

    // Annul at cycle 10 abandons the operation; no result may ever appear.
    @(negedge clk);
    dividend = 32'hFFFFFFFF; divisor = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall", 64'(stallreq_for_ex), 64'd0);
    @(negedge clk);
    check("annul_ready", 64'(ready_o), 64'd0);
    div_start = 1'b0; annul = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) saw_ready = 1'b1;
    end
    check("annul_no_result", 64'(saw_ready), 64'd0);
    run_op("after_annul_9_3", 32'd9, 32'd3, 1'b0, 33, {32'h00000000, 32'h00000003});

    // Reset in the middle of BUSY discards the work.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; div_signed = 1'b0; div_start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; div_start = 1'b0;
    @(negedge clk);
    check("midreset_ready", 64'(ready_o), 64'd0);
    check("midreset_result", result_o, 64'd0);
    check("midreset_stall", 64'(stallreq_for_ex), 64'd0);
    rst = 1'b0;
    run_op("after_reset", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, {32'h00000000, 32'h00000001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the EX stage of the 5-stage core.
- Executes DIV/DIVU and returns the quotient (to LO) and the remainder (to HI).
- While a division is in flight it raises stallreq_for_ex toward the pipeline controller, which freezes the earlier stages.
- One quotient bit per cycle; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- div_start  input  1  EX requests a divide; held high until ready_o is seen.
- div_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start in IDLE.
- dividend  input  WIDTH  operand A; sampled in IDLE.
- divisor  input  WIDTH  operand B; sampled in IDLE.
- annul  input  1  flush/cancel; abandons the current operation.
- result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o=1.
- ready_o  output  1  result valid this cycle.
- stallreq_for_ex  output  1  stall request to the pipeline controller.

Behaviour:
- Reset: state=IDLE; result_o=0, ready_o=0, stallreq_for_ex=0; internal registers cleared. Reset takes effect in any state and discards work in progress.
- stallreq_for_ex is combinational: div_start & ~ready_o & ~annul. It is high from the first request cycle until the cycle ready_o rises.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - Entered with div_start=1, annul=0, divisor==0 -> DIVZERO.
  - Entered with div_start=1, annul=0, divisor!=0 -> latch |A|, |B| (absolute values only when div_signed), latch sign flags, clear count -> BUSY.
  - Otherwise stay in IDLE.
- DIVZERO: result register <- 0 (quotient 0, remainder 0) -> DONE. No exception is raised.
- BUSY, each cycle:
  - Shift the {partial remainder, dividend} pair left by 1.
  - Trial subtract the divisor as a WIDTH+1-bit subtraction.
  - If no borrow, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - count++.
  - After WIDTH iterations (count==WIDTH-1 processed) -> DONE.
  - annul=1 in BUSY -> IDLE immediately; no result is produced.
- DONE:
  - Apply sign correction: negate the quotient if sign(A)^sign(B); negate the remainder if sign(A). Both only when signed.
  - Drive result_o and hold ready_o=1 while in DONE.
  - Leave DONE -> IDLE when div_start=0 or annul=1. If div_start stays high, stay in DONE with ready_o held.
- Latency: request seen in IDLE at cycle 0; BUSY cycles 1..WIDTH; ready_o=1 at cycle WIDTH+1 (33 for WIDTH=32). The divide-by-zero path reaches ready_o at cycle 2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
- Sign rules: signed operands use their two's-complement magnitude, so the most negative value's magnitude is WIDTH-bit unsigned 2^(WIDTH-1). Unsigned mode never negates.
- Back-to-back operations: a new div_start is accepted only in IDLE, i.e. at least one cycle after leaving DONE.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |A| < |B| (after sign handling) and divisor!=0, skip BUSY and go directly to DONE. Quotient is 0, remainder is the original dividend. ready_o rises at cycle 2.
- Not defined: every nonzero-divisor operation takes the full WIDTH BUSY cycles. Results are identical in both builds; only latency differs.

Test Plan:
- Unsigned 100 / 7, div_signed=0 -> ready_o at cycle 33, result_o={0x00000002, 0x0000000E}; stallreq_for_ex high cycles 0..32, low at 33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000.
- Divisor 0, dividend 0x12345678 -> ready_o at cycle 2, result_o=0, no hang.
- Start 0xFFFFFFFF / 3 unsigned, assert annul at cycle 10 -> IDLE next cycle, ready_o never rises; a following 9/3 returns {0, 3} at cycle 33.
- DIV_EARLY_OUT_EN: 5 / 9 unsigned -> ready_o at cycle 2, result {5, 0}. Without the macro, same result at cycle 33.
- Reset asserted mid-BUSY -> next cycle IDLE, all outputs 0.
